// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Sequential shift-add multiplier. One operand pair is accepted over a
//   valid/ready handshake. The product appears WIDTH cycles later and is held
//   until the consumer takes it. Signed operation works in sign-magnitude:
//   the magnitudes are multiplied and the result is negated at the end if needed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair A/B/sgn valid
//   in_ready   block can accept operands (IDLE)
//   A, B       multiplicand / multiplier, WIDTH bits
//   sgn        1 = two's-complement operands, 0 = unsigned
//   out_valid  P holds a completed product
//   out_ready  consumer accepts P
//   P          2*WIDTH-bit product
//   busy       iteration in progress
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] addend, acc_sum;

    always_comb begin
        // Magnitudes as unsigned WIDTH-bit values: the most negative operand
        // maps to 2^(WIDTH-1), which still fits.
        abs_a = (sgn && A[WIDTH-1]) ? -A : A;
        abs_b = (sgn && B[WIDTH-1]) ? -B : B;

        // Partial product for this iteration, aligned at bit position count.
        addend  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
        acc_sum = acc_q + addend;

        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        count_d     = count_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = abs_a;
                    mplier_d = abs_b;
                    neg_d    = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    // Final partial product is folded in before the sign fix-up.
                    p_d         = neg_q ? -acc_sum : acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = out_valid_q;
    assign P         = p_q;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier: generalised successor to the fixed 2-bit combinational multiplier. Width is set by a parameter. Signed or unsigned operation is chosen per transaction. Operands enter and results leave over valid/ready handshakes, so the block can sit directly behind the stimulus/exploration harness or inside a datapath. Latency is fixed at WIDTH cycles, giving a small-area point in the multiplier design space.

## Interface
- WIDTH, default 8, operand width in bits (legal 2..32); product is 2*WIDTH bits
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair A/B/sgn valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- sgn  input  1  1 = two's-complement signed operands, 0 = unsigned; sampled with A/B
- out_valid  output  1  P holds a completed product
- out_ready  input  1  consumer accepts P
- P  output  2*WIDTH  product; two's complement when sgn was 1
- busy  output  1  high in BUSY state

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready, capture operands:
    - mcand <= |A| (sign-magnitude conversion when sgn=1, else A).
    - mplier <= |B|.
    - neg <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]).
    - acc <= 0; count <= 0.
  - Go to BUSY.
- BUSY: each cycle, if mplier[0], add mcand to acc, aligned at bit position count.
  - Then shift mplier right and increment count.
  - Accumulator width is 2*WIDTH; no overflow is possible.
  - The conversion |x| is computed as an unsigned WIDTH-bit value, so the most negative value maps to 2^(WIDTH-1) with no overflow.
- The cycle with count == WIDTH-1 is the last iteration. At that edge:
  - Register P = neg ? -(final acc) : final acc, taken mod 2^(2*WIDTH).
  - Set out_valid=1 and go to DONE.
- DONE: P and out_valid are held stable while out_ready=0.
  - On out_valid & out_ready, clear out_valid and go to IDLE.
  - in_ready rises the cycle after; there is no same-cycle turnaround.
- in_valid in BUSY/DONE is ignored. A, B and sgn are not re-sampled after capture.
- Operand zero still takes the full WIDTH iterations; there is no early termination.
- Asynchronous reset at any time aborts the operation.
  - All state clears: state=IDLE, out_valid=0, busy=0, P=0, acc=0, count=0.
  - The aborted product is never presented.
  - Inputs are ignored while rst_n=0.

## Timing
- Reset values:
  - in_ready=1 (state IDLE)
  - out_valid=0
  - busy=0
  - P=0
- Acceptance edge = edge 0; busy=1 after edge 0.
- out_valid=1 and P valid after edge WIDTH, i.e. WIDTH cycles of latency.
- busy=0 from the same edge.
- With out_ready held high, the handshake completes at edge WIDTH+1 and in_ready=1 after it.
- Maximum throughput is one product per WIDTH+2 cycles.
- All outputs are registered or decoded directly from the state register; there is no combinational path from inputs to outputs.
- P changes only at the DONE-entry edge and at reset.

## Test plan
- WIDTH=2, unsigned, A=2, B=3, out_ready=1 -> out_valid after 2 edges, P=6. Repeat for all 16 pairs -> P=A*B.
- WIDTH=8, unsigned, A=255, B=255 -> P=65025 (0xFE01) exactly 8 cycles after acceptance. A=0, B=77 -> P=0, same latency.
- WIDTH=8, signed:
  - A=-128 (0x80), B=-128 -> P=16384 (0x4000).
  - A=-3 (0xFD), B=5 -> P=0xFFF1.
  - A=127, B=-1 -> P=0xFF81.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> P and out_valid stay constant and in_ready stays 0. Raising out_ready -> out_valid falls next edge and in_ready=1 the cycle after.
- in_valid held high with new A/B throughout BUSY/DONE -> the first product is unaffected. The second operand pair is accepted only once back in IDLE.
- rst_n pulsed low mid-BUSY (count=3), asynchronously and without a clock edge -> out_valid=0, P=0, in_ready=1 immediately. No stale product ever appears. The next transaction 5*6 -> P=30.
